dds_pulse_sequencer: RTL
========================

// Module: dds_pulse_sequencer
// PURPOSE
//  Sequences the AD9910-style DDS control pins from 16 trigger channels at clk_500m.
//  Latches each rising-edge trigger as a pending request and arbitrates among pending requests.
//  For the granted channel, runs profile select -> io_update -> DRCTL ramp -> hold -> release.
//  Sits between the trigger-pulse generator and the DDS pad drivers; its outputs are also the
//  signals tapped by the on-chip logic analyser.
// PARAMETERS
//  N_TRIG     16  number of trigger channels (power of 2; index width = $clog2(N_TRIG))
//  SETUP_CYC  4   cycles profile/osk are stable before io_update rises (>=1)
//  IOUP_W     8   io_update high width in cycles (>=1)
//  CNT_W      16  width of hold and timeout counters
// PORTS
//  clk_500m      in   1          system clock; the only clock
//  rst           in   1          synchronous, active-high reset
//  enable        in   1          1 = grants allowed; 0 = no new grant, the active sequence completes
//  triger_pulse  in   N_TRIG     trigger request, rising-edge sensitive
//  hold_cycles   in   CNT_W      HOLD length; sampled at grant
//  ramp_timeout  in   CNT_W      RAMP time limit; 0 = wait forever; sampled at grant
//  drover        in   1          DDS digital-ramp-over flag; asynchronous pad input
//  profile       out  log2(N)    DDS profile select = granted channel index
//  osk           out  1          output shift keying enable
//  drctl         out  1          digital ramp control
//  io_update     out  1          DDS register update strobe
//  pulse_position out 1          high during HOLD
//  busy          out  1          state != IDLE
//  seq_done      out  1          1-cycle pulse on leaving RELEASE
//  timeout_err   out  1          sticky: set when a RAMP timed out; cleared only by rst
//  overrun_err   out  1          sticky: set when a trigger hits an already-pending channel
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, pending cleared, profile 0. Reset mid-sequence aborts on
//   the same edge and drives osk, drctl and io_update low.
//  Edge detect: pending[i] is set on the edge after the edge where triger_pulse[i] is first seen
//   high (previous sample 0). A trigger on a pending channel merges and sets overrun_err.
//   The active channel may re-pend.
//  Grant: in IDLE with enable=1 and pending!=0, the next edge moves to SETUP, clears the
//   winner's pending bit, and loads profile, hold_cycles and ramp_timeout.
//   If a set and a clear hit the same bit on one edge, the set wins.
//  FSM:
//   IDLE -> SETUP: osk=1, profile held; lasts SETUP_CYC cycles.
//   SETUP -> IOUP: io_update=1 for IOUP_W cycles.
//   IOUP -> RAMP: drctl=1. Exit when drover_s=1, or when the timeout counter reaches
//    ramp_timeout (!=0); a timeout also sets timeout_err.
//   RAMP -> HOLD: drctl=1, pulse_position=1; lasts max(hold_cycles,1) cycles.
//   HOLD -> RELEASE: osk=0, drctl=0; 1 cycle, seq_done=1.
//   RELEASE -> IDLE. Back-to-back grants are possible: the next SETUP starts one cycle after
//    RELEASE.
//  drover goes through a 2-flop synchroniser (drover_s, +2 cycles latency).
//   drover_s already high on RAMP entry exits after 1 cycle.
//  Counters saturate and never wrap. Timeout compares count == ramp_timeout.
//  The timeout counter is cleared on RAMP entry; its first RAMP cycle counts 1.
// CONFIGURATION
//  DDS_SEQ_RR_EN defined: round-robin arbitration; search starts at (last_grant+1) mod N_TRIG,
//   and last_grant resets to N_TRIG-1.
//  DDS_SEQ_RR_EN undefined: fixed priority; lowest pending index wins.
// STRUCTURE
//  Package dds_seq_pkg: state enum (IDLE,SETUP,IOUP,RAMP,HOLD,RELEASE), IDX_W constant,
//   default widths.
//  Sub-module dds_seq_arbiter: pending vector + last_grant in, onehot/index + valid out;
//   contains the DDS_SEQ_RR_EN switch.
//  Top: edge detect, pending register, synchroniser, FSM, counters, sticky flags.
// TESTING
//  Single trigger: triger_pulse[3] rises, hold=10, drover asserted 20 cycles into RAMP
//   -> profile=3; io_update high 8 cycles; drctl high until 2 cycles after drover plus 10;
//   one seq_done pulse.
//  Simultaneous triggers on ch 5 and ch 2, fixed priority -> ch2 served, then ch5 back-to-back.
//   With DDS_SEQ_RR_EN and last_grant=3 -> ch5 first.
//  Timeout: ramp_timeout=50, drover never asserted -> RAMP lasts exactly 50 cycles;
//   timeout_err=1 and stays 1 across later sequences.
//  Overrun: two rising edges on ch7 while ch0 is active -> overrun_err=1; ch7 served once.
//  enable=0 with pending ch1 -> stays IDLE. enable=1 -> SETUP on the next edge.
//  rst asserted during IOUP -> next cycle all outputs 0, pending=0, IDLE.

Source files
------------

// File: rtl/dds_seq_pkg.sv
// Shared types and default widths for the DDS pulse sequencer.
package dds_seq_pkg;

    localparam int N_TRIG_DEF    = 16;
    localparam int IDX_W         = $clog2(N_TRIG_DEF);
    localparam int SETUP_CYC_DEF = 4;
    localparam int IOUP_W_DEF    = 8;
    localparam int CNT_W_DEF     = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        IOUP,
        RAMP,
        HOLD,
        RELEASE
    } dds_state_e;

endpackage

// File: rtl/dds_seq_arbiter.sv
// Pending-request arbiter, purely combinational; `DDS_SEQ_RR_EN selects round-robin
// starting after last_grant, otherwise lowest pending index wins.
module dds_seq_arbiter #(
    parameter int N = 16,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] pending,
    input  logic [W-1:0] last_grant,
    output logic [N-1:0] onehot,
    output logic [W-1:0] index,
    output logic         valid
);

    logic [W-1:0] cand;

`ifndef DDS_SEQ_RR_EN
    logic unused_last;
    assign unused_last = ^last_grant;
`endif

    // N is a power of two, so the W-bit add wraps the search modulo N.
    always_comb begin
        index = '0;
        valid = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
`ifdef DDS_SEQ_RR_EN
            cand = last_grant + W'(k + 1);
`else
            cand = W'(k);
`endif
            if (!valid && pending[cand]) begin
                index = cand;
                valid = 1'b1;
            end
        end
        onehot = valid ? (N'(1) << index) : '0;
    end

endmodule

// File: rtl/dds_pulse_sequencer.sv
// Latches trigger edges, grants one channel at a time and drives profile/io_update/drctl/osk
// (registered outputs, grant 3 edges after trigger rise); arbitration mode set by `DDS_SEQ_RR_EN.
module dds_pulse_sequencer
    import dds_seq_pkg::*;
#(
    parameter int N_TRIG    = N_TRIG_DEF,
    parameter int SETUP_CYC = SETUP_CYC_DEF,
    parameter int IOUP_W    = IOUP_W_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                      clk_500m,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [N_TRIG-1:0]         triger_pulse,
    input  logic [CNT_W-1:0]          hold_cycles,
    input  logic [CNT_W-1:0]          ramp_timeout,
    input  logic                      drover,
    output logic [$clog2(N_TRIG)-1:0] profile,
    output logic                      osk,
    output logic                      drctl,
    output logic                      io_update,
    output logic                      pulse_position,
    output logic                      busy,
    output logic                      seq_done,
    output logic                      timeout_err,
    output logic                      overrun_err
);

    localparam int IW = $clog2(N_TRIG);

    logic [N_TRIG-1:0] trig_s1_q, trig_s2_q, rise;
    logic [N_TRIG-1:0] pending_q, pending_d, gnt_oh;
    logic [IW-1:0]     gnt_idx, last_grant_q, profile_q;
    logic              gnt_vld, grant, ramp_to;
    logic              drover_m_q, drover_s_q;
    dds_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, hold_q, rto_q;
    logic              osk_q, drctl_q, ioup_q, pp_q, busy_q, done_q, to_err_q, ovr_err_q;

    dds_seq_arbiter #(.N(N_TRIG), .W(IW)) u_arb (
        .pending    (pending_q),
        .last_grant (last_grant_q),
        .onehot     (gnt_oh),
        .index      (gnt_idx),
        .valid      (gnt_vld)
    );

    assign rise      = trig_s1_q & ~trig_s2_q;
    assign grant     = (state_q == IDLE) && enable && gnt_vld;
    assign ramp_to   = (state_q == RAMP) && (rto_q != '0) && (cnt_q == rto_q);
    // A new edge on the bit being granted this cycle keeps it pending.
    assign pending_d = (pending_q & ~(grant ? gnt_oh : '0)) | rise;

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        case (state_q)
            IDLE:    if (grant) begin
                         state_d = SETUP;
                         cnt_d   = CNT_W'(1);
                     end
            SETUP:   if (cnt_q >= CNT_W'(SETUP_CYC)) begin
                         state_d = IOUP;
                         cnt_d   = CNT_W'(1);
                     end
            IOUP:    if (cnt_q >= CNT_W'(IOUP_W)) begin
                         state_d = RAMP;
                         cnt_d   = CNT_W'(1);
                     end
            RAMP:    if (drover_s_q || ramp_to) begin
                         state_d = HOLD;
                         cnt_d   = CNT_W'(1);
                     end
            HOLD:    if (cnt_q >= hold_q) state_d = RELEASE;
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with state_q.
    always_ff @(posedge clk_500m) begin
        if (rst) begin
            trig_s1_q    <= '0;
            trig_s2_q    <= '0;
            drover_m_q   <= 1'b0;
            drover_s_q   <= 1'b0;
            pending_q    <= '0;
            last_grant_q <= IW'(N_TRIG - 1);
            profile_q    <= '0;
            state_q      <= IDLE;
            cnt_q        <= '0;
            hold_q       <= '0;
            rto_q        <= '0;
            osk_q        <= 1'b0;
            drctl_q      <= 1'b0;
            ioup_q       <= 1'b0;
            pp_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            to_err_q     <= 1'b0;
            ovr_err_q    <= 1'b0;
        end else begin
            trig_s1_q  <= triger_pulse;
            trig_s2_q  <= trig_s1_q;
            drover_m_q <= drover;
            drover_s_q <= drover_m_q;
            pending_q  <= pending_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            if (grant) begin
                profile_q    <= gnt_idx;
                last_grant_q <= gnt_idx;
                hold_q       <= hold_cycles;
                rto_q        <= ramp_timeout;
            end
            osk_q   <= (state_d == SETUP) || (state_d == IOUP) ||
                       (state_d == RAMP)  || (state_d == HOLD);
            drctl_q <= (state_d == RAMP) || (state_d == HOLD);
            ioup_q  <= (state_d == IOUP);
            pp_q    <= (state_d == HOLD);
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == RELEASE);
            if (ramp_to)                to_err_q  <= 1'b1;
            if (|(rise & pending_q))    ovr_err_q <= 1'b1;
        end
    end

    assign profile        = profile_q;
    assign osk            = osk_q;
    assign drctl          = drctl_q;
    assign io_update      = ioup_q;
    assign pulse_position = pp_q;
    assign busy           = busy_q;
    assign seq_done       = done_q;
    assign timeout_err    = to_err_q;
    assign overrun_err    = ovr_err_q;

endmodule
